// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, complex bin type, bit-reversal helper
// and the unloader state encoding.
package fft_pkg;
    localparam int FFT_N      = 32;
    localparam int FFT_DATA_W = 16;

    typedef struct packed {
        logic signed [15:0] im;
        logic signed [15:0] re;
    } cplx_t;

    typedef enum logic {IDLE, STREAM} unload_state_t;

    // Reverse the low 'width' bits of idx; upper bits come back zero.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            if (i < width) r[i] = idx[5'(width - 1 - i)];
        return r;
    endfunction
endpackage

// File: rtl/fft_frame_unloader.sv
// Captures a parallel FFT frame on in_valid and streams it out one bin per beat,
// optionally in natural order from bit-reversed FFT output.
module fft_frame_unloader
    import fft_pkg::*;
#(
    parameter int N_POINTS    = FFT_N,
    parameter int DATA_W      = FFT_DATA_W,
    parameter int BIT_REVERSE = 1
) (
    input  logic                         clk_100MHz,
    input  logic                         rstn,
    input  logic                         in_valid,
    input  logic [N_POINTS*DATA_W-1:0]   in_re,
    input  logic [N_POINTS*DATA_W-1:0]   in_im,
    output logic [2*DATA_W-1:0]          m_tdata,
    output logic [$clog2(N_POINTS)-1:0]  m_tuser,
    output logic                         m_tlast,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic                         busy,
    output logic                         overflow,
    input  logic                         ovf_clr,
    output logic [15:0]                  frame_cnt
);
    localparam int IW = $clog2(N_POINTS);

    unload_state_t state, state_nxt;
    logic [IW-1:0] idx, rd_sel;
    cplx_t         frame_buf [N_POINTS];
    logic          xfer, last_beat, capture, drop;

    assign last_beat = (idx == IW'(N_POINTS - 1));
    assign xfer      = m_tvalid & m_tready;
    // A new frame is only accepted when the buffer is free or freeing this cycle.
    assign capture   = in_valid & ((state == IDLE) | (xfer & last_beat));
    assign drop      = in_valid & (state == STREAM) & ~(xfer & last_beat);
    assign rd_sel    = (BIT_REVERSE != 0) ? IW'(bitrev(32'(idx), IW)) : idx;

    always_ff @(posedge clk_100MHz or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = STREAM;
            STREAM:  if (xfer && last_beat && !in_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_tvalid = 1'b0;
        m_tuser  = '0;
        m_tdata  = '0;
        m_tlast  = 1'b0;
        busy     = 1'b0;
        if (state == STREAM) begin
            m_tvalid = 1'b1;
            busy     = 1'b1;
            m_tuser  = rd_sel;
            m_tdata  = frame_buf[rd_sel];
            m_tlast  = last_beat;
        end
    end

    always_ff @(posedge clk_100MHz or negedge rstn) begin
        if (!rstn) begin
            idx       <= '0;
            frame_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            if (capture)                idx <= '0;
            else if (xfer && !last_beat) idx <= idx + IW'(1);
            if (xfer && last_beat) frame_cnt <= frame_cnt + 16'd1;
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    // Buffer contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk_100MHz) begin
        if (capture)
            for (int k = 0; k < N_POINTS; k++)
                frame_buf[k] <= '{im: in_im[k*DATA_W +: DATA_W], re: in_re[k*DATA_W +: DATA_W]};
    end
endmodule
